sys_vga_ram_dp: RTL and testbench

// - Parametrised true dual-port Avalon-MM on-chip frame/line RAM for the VGA subsystem, single clock domain.
// - Port 1 serves the CPU/DMA master; port 2 serves the VGA pixel fetcher.
// - Provides a configurable read pipeline with readdatavalid and byte-lane write merging.
// - Forwards data between ports on same-address read/write, and has a hardware clear engine.

---
 rtl/sys_vga_ram_dp.sv | 203 ++++++++++++++++++++
 tb/tb_sys_vga_ram_dp.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_vga_ram_dp.sv
// True dual-port Avalon-MM frame/line RAM with read pipeline, write merging, cross-port forwarding and a clear engine.
// Optional collision counter output enabled by defining SYS_VGA_RAM_COLLISION_CNT_EN.
module sys_vga_ram_dp #(
    parameter int unsigned       DATA_W       = 32,
    parameter int unsigned       ADDR_W       = 11,
    parameter int unsigned       READ_LATENCY = 1,
    parameter                    INIT_FILE    = "sys_vga_ram.hex",
    parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic                   chipselect,
    input  logic                   read,
    input  logic                   write,
    input  logic [(DATA_W/8)-1:0]  byteenable,
    input  logic [DATA_W-1:0]      writedata,
    output logic [DATA_W-1:0]      readdata,
    output logic                   readdatavalid,
    output logic                   waitrequest,
    input  logic [ADDR_W-1:0]      address2,
    input  logic                   chipselect2,
    input  logic                   read2,
    input  logic                   write2,
    input  logic [(DATA_W/8)-1:0]  byteenable2,
    input  logic [DATA_W-1:0]      writedata2,
    output logic [DATA_W-1:0]      readdata2,
    output logic                   readdatavalid2,
    output logic                   waitrequest2,
    input  logic                   clear_start,
    output logic                   clear_busy
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
    ,
    output logic [15:0]            collision_count
`endif
);

    localparam int unsigned     BE_W      = DATA_W / 8;
    localparam int unsigned     DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_nxt;
    logic              busy_q, busy_nxt;
    logic              clr_we_c;
    logic              clr_go_c;

    logic              acc1_c, wr1_c, rd1_c;
    logic              acc2_c, wr2_c, rd2_c;
    logic [DATA_W-1:0] fwd1_c, fwd2_c;

    // Access qualification; a write beats a simultaneous read on the same port
    always_comb begin
        acc1_c = chipselect & (read | write) & ~busy_q;
        wr1_c  = acc1_c & write;
        rd1_c  = acc1_c & read & ~write;
        acc2_c = chipselect2 & (read2 | write2) & ~busy_q;
        wr2_c  = acc2_c & write2;
        rd2_c  = acc2_c & read2 & ~write2;
    end

    // Clear engine state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            clr_addr_q <= clr_addr_nxt;
            busy_q     <= busy_nxt;
        end
    end

    // Clear engine next-state: sweep every word once, one per cycle
    always_comb begin
        state_nxt    = state_q;
        clr_addr_nxt = clr_addr_q;
        clr_we_c     = 1'b0;
        clr_go_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_nxt    = ST_CLEAR;
                    clr_addr_nxt = '0;
                    clr_go_c     = 1'b1;
                end
            end
            ST_CLEAR: begin
                clr_we_c = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_nxt    = ST_IDLE;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt == ST_CLEAR);
    end

    assign clear_busy   = busy_q;
    assign waitrequest  = busy_q;
    assign waitrequest2 = busy_q;

    // Array update; port 1 is written last so it owns lanes enabled on both ports
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_addr_q] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr2_c && byteenable2[i]) begin
                    mem[address2][i*8 +: 8] <= writedata2[i*8 +: 8];
                end
                if (wr1_c && byteenable[i]) begin
                    mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    // Write-first forwarding of the other port's same-cycle write into each read
    always_comb begin
        fwd1_c = mem[address];
        fwd2_c = mem[address2];
        for (int i = 0; i < BE_W; i++) begin
            if (wr2_c && (address2 == address) && byteenable2[i]) begin
                fwd1_c[i*8 +: 8] = writedata2[i*8 +: 8];
            end
            if (wr1_c && (address == address2) && byteenable[i]) begin
                fwd2_c[i*8 +: 8] = writedata[i*8 +: 8];
            end
        end
    end

    // Read return pipeline; readdata only changes when a valid is delivered
    if (READ_LATENCY == 2) begin : g_lat2
        logic              v1_q, v2_q;
        logic [DATA_W-1:0] d1_q, d2_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v1_q           <= 1'b0;
                v2_q           <= 1'b0;
                d1_q           <= '0;
                d2_q           <= '0;
                readdatavalid  <= 1'b0;
                readdatavalid2 <= 1'b0;
                readdata       <= '0;
                readdata2      <= '0;
            end else begin
                v1_q           <= rd1_c;
                v2_q           <= rd2_c;
                readdatavalid  <= v1_q;
                readdatavalid2 <= v2_q;
                if (rd1_c) d1_q <= fwd1_c;
                if (rd2_c) d2_q <= fwd2_c;
                if (v1_q) readdata  <= d1_q;
                if (v2_q) readdata2 <= d2_q;
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                readdatavalid  <= 1'b0;
                readdatavalid2 <= 1'b0;
                readdata       <= '0;
                readdata2      <= '0;
            end else begin
                readdatavalid  <= rd1_c;
                readdatavalid2 <= rd2_c;
                if (rd1_c) readdata  <= fwd1_c;
                if (rd2_c) readdata2 <= fwd2_c;
            end
        end
    end

`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
    logic coll_c;

    assign coll_c = wr1_c & wr2_c & (address == address2) & (|(byteenable & byteenable2));

    // Saturating count of overlapping same-address dual writes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            collision_count <= '0;
        end else if (clr_go_c) begin
            collision_count <= '0;
        end else if (coll_c && (collision_count != 16'hFFFF)) begin
            collision_count <= collision_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sys_vga_ram_dp.sv
// Directed self-checking bench for sys_vga_ram_dp: one READ_LATENCY=1 instance and one READ_LATENCY=2 instance.
module tb_sys_vga_ram_dp;

    localparam logic [31:0] CLR = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [10:0] address, address2;
    logic        chipselect, read, write, chipselect2, read2, write2;
    logic [3:0]  byteenable, byteenable2;
    logic [31:0] writedata, writedata2, readdata, readdata2;
    logic        readdatavalid, readdatavalid2, waitrequest, waitrequest2;
    logic        clear_start, clear_busy;

    logic [10:0] b_address, b_address2;
    logic        b_cs, b_read, b_write, b_cs2, b_read2, b_write2;
    logic [3:0]  b_be, b_be2;
    logic [31:0] b_wd, b_wd2, b_readdata, b_readdata2;
    logic        b_readdatavalid, b_readdatavalid2, b_waitrequest, b_waitrequest2;
    logic        b_clear_start, b_clear_busy;

`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
    logic [15:0] collision_count, b_collision_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sys_vga_ram_dp #(
        .DATA_W(32), .ADDR_W(11), .READ_LATENCY(1), .INIT_FILE(""), .CLEAR_VALUE(CLR)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .address2(address2), .chipselect2(chipselect2), .read2(read2), .write2(write2),
        .byteenable2(byteenable2), .writedata2(writedata2), .readdata2(readdata2),
        .readdatavalid2(readdatavalid2), .waitrequest2(waitrequest2),
        .clear_start(clear_start), .clear_busy(clear_busy)
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        , .collision_count(collision_count)
`endif
    );

    sys_vga_ram_dp #(
        .DATA_W(32), .ADDR_W(11), .READ_LATENCY(2), .INIT_FILE(""), .CLEAR_VALUE(32'h0)
    ) dut2 (
        .clk(clk), .reset_n(reset_n),
        .address(b_address), .chipselect(b_cs), .read(b_read), .write(b_write),
        .byteenable(b_be), .writedata(b_wd), .readdata(b_readdata),
        .readdatavalid(b_readdatavalid), .waitrequest(b_waitrequest),
        .address2(b_address2), .chipselect2(b_cs2), .read2(b_read2), .write2(b_write2),
        .byteenable2(b_be2), .writedata2(b_wd2), .readdata2(b_readdata2),
        .readdatavalid2(b_readdatavalid2), .waitrequest2(b_waitrequest2),
        .clear_start(b_clear_start), .clear_busy(b_clear_busy)
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        , .collision_count(b_collision_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic p1_idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0; byteenable = '0; writedata = '0;
    endtask

    task automatic p2_idle();
        chipselect2 = 1'b0; read2 = 1'b0; write2 = 1'b0; byteenable2 = '0; writedata2 = '0;
    endtask

    task automatic p1_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; chipselect = 1'b1; write = 1'b1; read = 1'b0; byteenable = be; writedata = d;
        step();
        p1_idle();
    endtask

    task automatic p2_write(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        address2 = a; chipselect2 = 1'b1; write2 = 1'b1; read2 = 1'b0; byteenable2 = be; writedata2 = d;
        step();
        p2_idle();
    endtask

    task automatic p1_read_chk(input logic [10:0] a, input logic [31:0] exp, input string tag);
        address = a; chipselect = 1'b1; read = 1'b1;
        step();
        p1_idle();
        check({tag, " p1 valid"}, 32'(readdatavalid), 32'd1);
        check({tag, " p1 data"}, readdata, exp);
    endtask

    task automatic p2_read_chk(input logic [10:0] a, input logic [31:0] exp, input string tag);
        address2 = a; chipselect2 = 1'b1; read2 = 1'b1;
        step();
        p2_idle();
        check({tag, " p2 valid"}, 32'(readdatavalid2), 32'd1);
        check({tag, " p2 data"}, readdata2, exp);
    endtask

    task automatic dual_write(input logic [10:0] a1, input logic [31:0] d1, input logic [3:0] be1,
                              input logic [10:0] a2, input logic [31:0] d2, input logic [3:0] be2);
        address  = a1; chipselect  = 1'b1; write  = 1'b1; byteenable  = be1; writedata  = d1;
        address2 = a2; chipselect2 = 1'b1; write2 = 1'b1; byteenable2 = be2; writedata2 = d2;
        step();
        p1_idle();
        p2_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] b2b_addr [3];
        logic [31:0] b2b_exp  [3];
        int cnt;
        int nv;

        reset_n = 1'b0;
        p1_idle(); p2_idle(); clear_start = 1'b0; address = '0; address2 = '0;
        b_address = '0; b_cs = 1'b0; b_read = 1'b0; b_write = 1'b0; b_be = '0; b_wd = '0;
        b_address2 = '0; b_cs2 = 1'b0; b_read2 = 1'b0; b_write2 = 1'b0; b_be2 = '0; b_wd2 = '0;
        b_clear_start = 1'b0;
        repeat (3) step();

        check("rst readdata", readdata, 32'h0);
        check("rst readdata2", readdata2, 32'h0);
        check("rst rdv", 32'(readdatavalid), 32'd0);
        check("rst rdv2", 32'(readdatavalid2), 32'd0);
        check("rst waitreq", 32'(waitrequest), 32'd0);
        check("rst waitreq2", 32'(waitrequest2), 32'd0);
        check("rst busy", 32'(clear_busy), 32'd0);
        check("rst b busy", 32'(b_clear_busy), 32'd0);
        check("rst b waitreq", 32'({b_waitrequest, b_waitrequest2}), 32'd0);
        reset_n = 1'b1;
        step();

        // Basic write on port 1, read on port 2
        p1_write(11'h005, 32'hDEADBEEF, 4'hF);
        p2_read_chk(11'h005, 32'hDEADBEEF, "t1");
        step();
        check("t1 rdv pulse", 32'(readdatavalid2), 32'd0);
        check("t1 hold", readdata2, 32'hDEADBEEF);

        // Byte-lane merge, then a byteenable=0 no-op write
        p1_write(11'h020, 32'h11223344, 4'hF);
        p2_write(11'h020, 32'hAABBCCDD, 4'b0101);
        p1_read_chk(11'h020, 32'h11BB33DD, "t2");
        p1_write(11'h020, 32'hFFFFFFFF, 4'h0);
        p2_read_chk(11'h020, 32'h11BB33DD, "be0");

        // Same-address dual writes: overlapping, then disjoint lanes
        dual_write(11'h7FF, 32'h0, 4'hF, 11'h7FF, 32'hFFFFFFFF, 4'h3);
        p1_read_chk(11'h7FF, 32'h00000000, "t3");
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        check("coll one", 32'(collision_count), 32'd1);
`endif
        dual_write(11'h040, 32'h11111111, 4'h3, 11'h040, 32'h22222222, 4'hC);
        p2_read_chk(11'h040, 32'h22221111, "disjoint");
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        check("coll disjoint", 32'(collision_count), 32'd1);
`endif

        // Write-first forwarding both directions
        address = 11'h010; chipselect = 1'b1; write = 1'b1; byteenable = 4'hF; writedata = 32'h12345678;
        address2 = 11'h010; chipselect2 = 1'b1; read2 = 1'b1;
        step(); p1_idle(); p2_idle();
        check("fwd p2 valid", 32'(readdatavalid2), 32'd1);
        check("fwd p2 data", readdata2, 32'h12345678);
        address2 = 11'h010; chipselect2 = 1'b1; write2 = 1'b1; byteenable2 = 4'h8; writedata2 = 32'hAA000000;
        address = 11'h010; chipselect = 1'b1; read = 1'b1;
        step(); p1_idle(); p2_idle();
        check("fwd p1 valid", 32'(readdatavalid), 32'd1);
        check("fwd p1 data", readdata, 32'hAA345678);

        // Read and write together: write wins, no valid
        address = 11'h030; chipselect = 1'b1; read = 1'b1; write = 1'b1; byteenable = 4'hF; writedata = 32'hCAFEF00D;
        step(); p1_idle();
        check("rw no valid", 32'(readdatavalid), 32'd0);
        check("rw hold", readdata, 32'hAA345678);
        p1_read_chk(11'h030, 32'hCAFEF00D, "rw");

        // Back-to-back reads
        b2b_addr[0] = 11'h005; b2b_exp[0] = 32'hDEADBEEF;
        b2b_addr[1] = 11'h020; b2b_exp[1] = 32'h11BB33DD;
        b2b_addr[2] = 11'h010; b2b_exp[2] = 32'hAA345678;
        for (int k = 0; k < 3; k++) begin
            address = b2b_addr[k]; chipselect = 1'b1; read = 1'b1;
            step();
            check("b2b valid", 32'(readdatavalid), 32'd1);
            check("b2b data", readdata, b2b_exp[k]);
        end
        p1_idle();
        step();
        check("b2b end", 32'(readdatavalid), 32'd0);

        // Full clear with a read accepted alongside clear_start
        address2 = 11'h020; chipselect2 = 1'b1; read2 = 1'b1; clear_start = 1'b1;
        step();
        clear_start = 1'b0; p2_idle();
        check("clr rd valid", 32'(readdatavalid2), 32'd1);
        check("clr rd data", readdata2, 32'h11BB33DD);
        check("clr busy", 32'(clear_busy), 32'd1);
        check("clr waitreq", 32'({waitrequest, waitrequest2}), 32'd3);
        address = 11'h005; chipselect = 1'b1; read = 1'b1;
        cnt = 0; nv = 0;
        while (clear_busy && cnt < 5000) begin
            cnt++;
            if (readdatavalid) nv++;
            clear_start = (cnt == 500);
            step();
        end
        clear_start = 1'b0;
        check("clr cycles", 32'(cnt), 32'd2048);
        check("clr stalled", 32'(nv), 32'd0);
        check("clr waitreq low", 32'({waitrequest, waitrequest2}), 32'd0);
        step();
        p1_idle();
        check("post clr valid", 32'(readdatavalid), 32'd1);
        check("post clr data", readdata, CLR);
        p2_read_chk(11'h7FF, CLR, "clr top");
        p1_read_chk(11'h030, CLR, "clr mid");
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        check("coll cleared", 32'(collision_count), 32'd0);
`endif

        // Clear aborted by reset at clear cycle 100
        p1_write(11'h7FF, 32'h5A5A5A5A, 4'hF);
        p1_write(11'h005, 32'hDEADBEEF, 4'hF);
        p1_write(11'h200, 32'h77777777, 4'hF);
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        repeat (100) step();
        check("abort busy before", 32'(clear_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort busy", 32'(clear_busy), 32'd0);
        check("abort waitreq", 32'({waitrequest, waitrequest2}), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check("abort stays idle", 32'(clear_busy), 32'd0);
        p2_read_chk(11'h7FF, 32'h5A5A5A5A, "abort keep");
        p1_read_chk(11'h200, 32'h77777777, "abort keep2");
        p1_read_chk(11'h005, CLR, "abort swept");

        // READ_LATENCY=2 instance: 8 pipelined reads
        for (int i = 0; i < 8; i++) begin
            b_address = 11'(i); b_cs = 1'b1; b_write = 1'b1; b_be = 4'hF; b_wd = 32'hC0DE0000 + 32'(i);
            step();
        end
        b_cs = 1'b0; b_write = 1'b0; b_be = '0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                b_address2 = 11'(k); b_cs2 = 1'b1; b_read2 = 1'b1;
            end else begin
                b_cs2 = 1'b0; b_read2 = 1'b0;
            end
            step();
            if (k >= 1 && k <= 8) begin
                check("lat2 valid", 32'(b_readdatavalid2), 32'd1);
                check("lat2 data", b_readdata2, 32'hC0DE0000 + 32'(k - 1));
            end else begin
                check("lat2 idle", 32'(b_readdatavalid2), 32'd0);
            end
        end
        check("lat2 hold", b_readdata2, 32'hC0DE0007);
        check("lat2 p1 quiet", 32'(b_readdatavalid), 32'd0);
        check("lat2 p1 data", b_readdata, 32'h0);
`ifdef SYS_VGA_RAM_COLLISION_CNT_EN
        check("lat2 coll", 32'(b_collision_count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
